divide: RTL and testbench
=========================

Name: divide

Overview:
Iterative radix-2 restoring integer divider and the inverse companion of the iterative multiply unit. It serves the execute stage's DIV/DIVU/REM/REMU ops and produces quotient and remainder together. It uses the same ready/valid_in request and valid_out/yumi_in result handshake as the multiplier, so both units plug into the same issue and writeback slots. Result semantics follow RISC-V M-extension rules, including divide-by-zero and signed overflow.

Parameters:
WIDTH, 32, operand/result width in bits; latency scales with it.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
dividend  input  WIDTH  numerator; sampled only on the accept edge
divisor  input  WIDTH  denominator; sampled only on the accept edge
is_signed  input  1  1 = two's-complement divide; 0 = unsigned; sampled on the accept edge
valid_in  input  1  request valid
ready  output  1  unit idle and able to accept
valid_out  output  1  quotient/remainder valid
yumi_in  input  1  consumer takes the result; meaningful only while valid_out=1
quotient  output  WIDTH  quotient, truncated toward zero
remainder  output  WIDTH  remainder; sign follows the dividend
div_by_zero  output  1  flag: the current result came from divisor==0

Behaviour:
- Reset (a synchronous edge with reset=1, which takes priority over everything): state=S_IDLE, ready=1, valid_out=0, quotient=0, remainder=0, div_by_zero=0. Reset during S_CALC, S_FIX or S_DONE aborts the operation; no result is emitted.
- States: S_IDLE, S_CALC, S_FIX, S_DONE. ready=(state==S_IDLE); valid_out=(state==S_DONE).
- Accept edge: a clock edge with state==S_IDLE and valid_in=1. valid_in is ignored in all other states, and operands may change freely then.
- On the accept edge, latch the operand signs. When is_signed=1, load magnitudes |dividend| and |divisor| (abs of the minimum value is that value read as unsigned). Clear the partial remainder and set iteration counter=WIDTH.
- Special cases, decided on the accept edge, go directly to S_DONE, so valid_out rises 1 edge after accept:
  - divisor==0: quotient=all ones, remainder=dividend, div_by_zero=1. Applies to both signed and unsigned.
  - is_signed=1, dividend==min negative value (0x80000000), divisor==all ones (-1): quotient=dividend, remainder=0, div_by_zero=0.
- Normal path: S_IDLE -> S_CALC.
  - Each S_CALC edge shifts {rem, quo} left by 1. If rem >= divisor magnitude, subtract it and set the quotient LSB=1. Then decrement the counter.
  - The subtraction uses a WIDTH+1-bit compare so no carry is lost.
  - After WIDTH iterations (the counter reaches 0), go to S_FIX.
- S_FIX (1 edge): if signed and the dividend sign != divisor sign, negate the quotient. If signed and the dividend is negative, negate the remainder. Then go to S_DONE.
- Latency for normal operations: valid_out rises WIDTH+2 edges after the accept edge (34 for WIDTH=32), independent of operand values.
- S_DONE: quotient, remainder and div_by_zero are held stable until consumed.
  - The edge with yumi_in=1 returns the unit to S_IDLE and drops valid_out; outputs keep their last values.
  - ready=1 on the following cycle, so back-to-back operations have at least 1 idle cycle between valid_out falling and the next accept.
- yumi_in outside S_DONE is ignored. valid_in in the same cycle as yumi_in is not accepted (ready=0).

Test Plan:
- Unsigned 100 / 7, is_signed=0 -> quotient=14, remainder=2, div_by_zero=0; valid_out rises exactly 34 edges after accept; ready=0 throughout.
- Signed -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7 / -2 -> quotient=-3, remainder=1. Signed -7 / -2 -> quotient=3, remainder=-1.
- Divide by zero: 5 / 0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, valid_out 1 edge after accept. Repeat with is_signed=1, dividend=-5 -> remainder=0xFFFFFFFB.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, 1-edge latency. The same operands unsigned -> quotient=0, remainder=0x80000000 via the normal 34-edge path.
- Backpressure: hold yumi_in=0 for 10 cycles in S_DONE with 0xFFFFFFFF / 1 unsigned -> outputs stay 0xFFFFFFFF / 0 and valid_out stays high. Toggle operand inputs meanwhile -> no effect. yumi_in=1 -> valid_out=0 next cycle, then ready=1.
- Reset at iteration 10 of 1000 / 3 -> next cycle ready=1, valid_out=0, outputs 0. A new request 9 / 3 then completes with quotient=3, remainder=0.

Source files
------------

// File: rtl/divide_if.sv
// Request/result bundle shared by the divider and its requester.
// valid_in/ready: a request transfers on a clock edge where both are high.
// valid_out/yumi_in: a result transfers on a clock edge where both are high.
interface divide_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             valid_in;
    logic             ready;
    logic             valid_out;
    logic             yumi_in;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output dividend, divisor, is_signed, valid_in, yumi_in,
        input  ready, valid_out, quotient, remainder, div_by_zero
    );

    modport slave (
        input  dividend, divisor, is_signed, valid_in, yumi_in,
        output ready, valid_out, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divide.sv
// Iterative radix-2 restoring divider with RISC-V M-extension result rules.
// One quotient bit per cycle on magnitudes, then a single sign-fix cycle.
module divide #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    divide_if.slave    bus,
    output logic [1:0] fsm_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, dbz;

    logic             accept, is_zero, is_ovf;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] diff;
    logic             ge;

    assign accept  = (state == S_IDLE) && bus.valid_in;
    assign is_zero = (bus.divisor == '0);
    assign is_ovf  = bus.is_signed && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                     && (bus.divisor == '1);
    // Negating the most negative value yields itself, which read unsigned is its magnitude.
    assign mag_a   = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign mag_b   = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    // WIDTH+1-bit partial remainder keeps the shifted-out bit for the compare.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign ge        = (rem_shift >= {1'b0, dvs});
    assign diff      = rem_shift[WIDTH-1:0] - dvs;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept) next_state = (is_zero || is_ovf) ? S_DONE : S_CALC;
            S_CALC: if (cnt == CW'(1)) next_state = S_FIX;
            S_FIX:  next_state = S_DONE;
            S_DONE: if (bus.yumi_in) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        neg_q <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        neg_r <= bus.is_signed & bus.dividend[WIDTH-1];
                        dvs   <= mag_b;
                        cnt   <= CW'(WIDTH);
                        if (is_zero) begin
                            quo <= '1;
                            rem <= bus.dividend;
                            dbz <= 1'b1;
                        end else if (is_ovf) begin
                            quo <= bus.dividend;
                            rem <= '0;
                            dbz <= 1'b0;
                        end else begin
                            quo <= mag_a;
                            rem <= '0;
                            dbz <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    rem <= ge ? diff : rem_shift[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt - CW'(1);
                end
                S_FIX: begin
                    if (neg_q) quo <= -quo;
                    if (neg_r) rem <= -rem;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready       = (state == S_IDLE);
    assign bus.valid_out   = (state == S_DONE);
    assign bus.quotient    = quo;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
    assign fsm_state       = state;
endmodule

// File: tb/tb_divide.sv
// Scoreboarded bench for the iterative divider: directed M-extension cases,
// backpressure, mid-operation reset and a batch of random operands.
module tb_divide;
  localparam int W  = 32;
  localparam int PW = 2 * W + 1;

  logic       clk;
  logic       reset;
  logic [1:0] fsm_state;

  divide_if #(.WIDTH(W)) bus ();

  divide #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // {div_by_zero, quotient, remainder}
  logic [PW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sgn);
    logic [W-1:0] q, r;
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, a, {W{1'b0}}};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_timeout", {63'd0, bus.ready}, 64'd1);
  endtask

  task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.is_signed = sgn;
    bus.valid_in  = 1'b1;
    @(posedge clk); #1;
    bus.valid_in  = 1'b0;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input logic [PW-1:0] exp, input int exp_lat, input int hold);
    int lat;
    logic ready_seen;
    logic [PW-1:0] e;
    wait_ready();
    exp_q.push_back(exp);
    drive_req(a, b, sgn);
    lat = 1;
    ready_seen = 1'b0;
    while (!bus.valid_out && lat < 100) begin
      if (bus.ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("ready_low_busy", {63'd0, ready_seen}, 64'd0);
    e = exp_q.pop_front();
    check("quotient", 64'(bus.quotient), 64'(e[2*W-1:W]));
    check("remainder", 64'(bus.remainder), 64'(e[W-1:0]));
    check("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e[2*W]});
    for (int i = 0; i < hold; i++) begin
      bus.dividend  = $urandom;
      bus.divisor   = $urandom;
      bus.is_signed = 1'($urandom_range(0, 1));
      bus.valid_in  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_valid", {63'd0, bus.valid_out}, 64'd1);
      check("hold_q", 64'(bus.quotient), 64'(e[2*W-1:W]));
      check("hold_r", 64'(bus.remainder), 64'(e[W-1:0]));
    end
    // valid_in high alongside yumi_in must not start a new operation.
    bus.valid_in = 1'b1;
    bus.yumi_in  = 1'b1;
    @(posedge clk); #1;
    bus.yumi_in  = 1'b0;
    bus.valid_in = 1'b0;
    check("post_yumi_valid", {63'd0, bus.valid_out}, 64'd0);
    check("post_yumi_ready", {63'd0, bus.ready}, 64'd1);
    check("post_yumi_q", 64'(bus.quotient), 64'(e[2*W-1:W]));
    @(posedge clk); #1;
    check("no_accept_with_yumi", 64'(fsm_state), 64'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic sgn;
    logic [PW-1:0] m;
    reset         = 1'b1;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.is_signed = 1'b0;
    bus.valid_in  = 1'b0;
    bus.yumi_in   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready", {63'd0, bus.ready}, 64'd1);
    check("rst_valid", {63'd0, bus.valid_out}, 64'd0);
    check("rst_q", 64'(bus.quotient), 64'd0);
    check("rst_r", 64'(bus.remainder), 64'd0);
    check("rst_dbz", {63'd0, bus.div_by_zero}, 64'd0);

    run_op(32'd100, 32'd7, 1'b0, {1'b0, 32'd14, 32'd2}, 34, 0);
    run_op(-32'sd7, 32'd2, 1'b1, {1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF}, 34, 0);
    run_op(32'd7, -32'sd2, 1'b1, {1'b0, 32'hFFFF_FFFD, 32'd1}, 34, 0);
    run_op(-32'sd7, -32'sd2, 1'b1, {1'b0, 32'd3, 32'hFFFF_FFFF}, 34, 0);
    run_op(32'd5, 32'd0, 1'b0, {1'b1, 32'hFFFF_FFFF, 32'd5}, 1, 0);
    run_op(-32'sd5, 32'd0, 1'b1, {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB}, 1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {1'b0, 32'h8000_0000, 32'd0}, 1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {1'b0, 32'd0, 32'h8000_0000}, 34, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, {1'b0, 32'hFFFF_FFFF, 32'd0}, 34, 10);

    // Reset aborts an operation in flight; nothing is emitted for it.
    wait_ready();
    drive_req(32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ready", {63'd0, bus.ready}, 64'd1);
    check("abort_valid", {63'd0, bus.valid_out}, 64'd0);
    check("abort_q", 64'(bus.quotient), 64'd0);
    check("abort_r", 64'(bus.remainder), 64'd0);
    run_op(32'd9, 32'd3, 1'b0, {1'b0, 32'd3, 32'd0}, 34, 0);

    for (int i = 0; i < 20; i++) begin
      a   = $urandom;
      b   = (i % 4 == 0) ? W'($urandom_range(1, 50)) : $urandom;
      if (i % 7 == 3) b = '0;
      sgn = 1'($urandom_range(0, 1));
      if (i % 5 == 2) a = W'($urandom_range(0, 1000));
      m = model(a, b, sgn);
      run_op(a, b, sgn, m,
             (b == '0 || (sgn && a == 32'h8000_0000 && b == '1)) ? 1 : 34,
             int'($urandom_range(0, 3)));
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
